// File: rtl/fp13_adder.sv
// rtl/fp13_adder.sv - registered fp_t adder/subtractor; ROUND_NEAREST_EN selects round-to-nearest-even
module fp13_adder #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 3;            // mantissa plus guard, round, sticky
  localparam int SHW = (1 << EXP_W) - 1;     // largest possible alignment shift
  localparam int EW  = EXP_W + 1;            // exponent with headroom for overflow

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic              a_big;
  logic              s_big;
  logic [EXP_W-1:0]  e_big, e_sml, d;
  logic [MAN_W-1:0]  m_big, m_sml;
  logic [XW+SHW-1:0] wide;
  logic [XW-1:0]     sml_ext;
  logic [XW:0]       sum;
  logic [XW-1:0]     m;
  logic [EW-1:0]     e;
  logic              sgn;
  logic [MAN_W-1:0]  man;
  logic [W-1:0]      nxt_result;
  logic              nxt_ovf;
`ifdef ROUND_NEAREST_EN
  logic              rnd;
  logic [MAN_W:0]    man_r;
`endif

  // Combinational datapath: order operands, align, add/sub, normalize, round, saturate.
  always_comb begin
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    s_big = a_big ? sa : sb;
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    m_big = a_big ? ma : mb;
    m_sml = a_big ? mb : ma;
    d     = e_big - e_sml;

    // Shift the small mantissa into a wide field so every dropped bit lands in
    // the low part, then fold those bits into the sticky position.
    wide    = {m_sml, 3'b000, {SHW{1'b0}}} >> d;
    sml_ext = {wide[XW+SHW-1:SHW+1], wide[SHW] | (|wide[SHW-1:0])};

    sgn = s_big;
    if (sa == sb) begin
      sum = {1'b0, m_big, 3'b000} + {1'b0, sml_ext};
    end else begin
      sum = {1'b0, m_big, 3'b000} - {1'b0, sml_ext};
      // Only an unnormalized big operand can come out negative; fix magnitude and sign.
      if (sum[XW]) begin
        sum = (XW+1)'(0) - sum;
        sgn = ~s_big;
      end
    end

    m = sum[XW-1:0];
    e = {1'b0, e_big};
    if (sum[XW]) begin
      m = {sum[XW:2], sum[1] | sum[0]};
      e = e + EW'(1);
    end else begin
      // Left-normalize, stopping at exponent 0 for gradual underflow.
      for (int i = 0; i < XW; i++) begin
        if (!m[XW-1] && (e != '0)) begin
          m = m << 1;
          e = e - EW'(1);
        end
      end
    end

    man = m[XW-1:3];
`ifdef ROUND_NEAREST_EN
    rnd   = m[2] & (m[1] | m[0] | m[3]);
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
    if (man_r[MAN_W]) begin
      man = {1'b1, {(MAN_W-1){1'b0}}};
      e   = e + EW'(1);
    end else begin
      man = man_r[MAN_W-1:0];
    end
`endif

    nxt_ovf    = 1'b0;
    nxt_result = {sgn, e[EXP_W-1:0], man};
    if (e > EW'(SHW)) begin
      nxt_result = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      nxt_ovf    = 1'b1;
    end

    // Zero operands bypass the arithmetic; exact cancellation gives +0.
    if ((ma == '0) && (mb == '0)) begin
      nxt_result = '0;
      nxt_ovf    = 1'b0;
    end else if (ma == '0) begin
      nxt_result = b;
      nxt_ovf    = 1'b0;
    end else if (mb == '0) begin
      nxt_result = a;
      nxt_ovf    = 1'b0;
    end else if (sum == '0) begin
      nxt_result = '0;
      nxt_ovf    = 1'b0;
    end
  end

  // Output register: capture on in_valid, hold otherwise, pulse out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= nxt_result;
        overflow <= nxt_ovf;
      end
    end
  end
endmodule

// File: tb/tb_fp13_adder.sv
// tb/tb_fp13_adder.sv - scoreboard bench for fp13_adder against an exact-arithmetic model
module tb_fp13_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] a, b;
  logic        out_valid;
  logic [12:0] result;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  logic [13:0] exp_q[$];
  logic [13:0] last_exp;

  always #5 clk = ~clk;

  fp13_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .overflow(overflow)
  );

  // Exact value of an fp_t in units of 2^-8 is man << exp; sum exactly, then re-encode.
  function automatic logic [13:0] model(input logic [12:0] x, input logic [12:0] y);
    longint va, vb, s, mag, man, rem, half;
    int e;
    if (x[7:0] == 0 && y[7:0] == 0) return 14'h0;
    if (x[7:0] == 0) return {1'b0, y};
    if (y[7:0] == 0) return {1'b0, x};
    va = longint'(x[7:0]) << x[11:8];
    vb = longint'(y[7:0]) << y[11:8];
    if (x[12]) va = -va;
    if (y[12]) vb = -vb;
    s = va + vb;
    if (s == 0) return 14'h0;
    mag = (s < 0) ? -s : s;
    e = 0;
    while ((mag >> e) >= 256) e++;
    man = mag >> e;
`ifdef ROUND_NEAREST_EN
    if (e > 0) begin
      rem  = mag & ((longint'(1) << e) - 1);
      half = longint'(1) << (e - 1);
      if (rem > half || (rem == half && man[0])) man++;
      if (man == 256) begin
        man = 128;
        e++;
      end
    end
`else
    rem  = 0;
    half = 0;
`endif
    if (e > 15) return {1'b1, (s < 0), 4'hF, 8'hFF};
    return {1'b0, (s < 0), 4'(e), 8'(man)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic issue_exp(input logic [12:0] x, input logic [12:0] y, input logic [13:0] want);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    in_valid = 1'b1;
    exp_q.push_back(want);
    last_exp = want;
  endtask

  task automatic issue(input logic [12:0] x, input logic [12:0] y);
    issue_exp(x, y, model(x, y));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [12:0] rnd_op();
    logic [7:0] mn;
    if ($urandom_range(7) == 0) mn = 8'h00;
    else mn = 8'h80 | 8'($urandom_range(127));
    return {1'($urandom_range(1)), 4'($urandom_range(15)), mn};
  endfunction

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got result %h with no pending operation", result);
      end else begin
        logic [13:0] w;
        w = exp_q.pop_front();
        check("sum", {2'b00, overflow, result}, {2'b00, w});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [12:0] x, y;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {2'b00, out_valid, overflow, result}, 16'h0);

    issue_exp(13'b0_0001_10000000, 13'b0_0001_10000000, {1'b0, 13'b0_0010_10000000});
    issue_exp(13'b0_0111_10000000, 13'b0_0001_10000000, {1'b0, 13'b0_0111_10000010});
    issue_exp(13'b0_0011_10100000, 13'b0_0010_10010000, {1'b0, 13'b0_0011_11101000});
    issue_exp(13'b0_0000_10000000, 13'b1_0001_11110000, {1'b0, 13'b1_0001_10110000});
`ifdef ROUND_NEAREST_EN
    issue_exp(13'b0_0001_11110000, 13'b0_0011_11111111, {1'b0, 13'b0_0100_10011110});
`else
    issue_exp(13'b0_0001_11110000, 13'b0_0011_11111111, {1'b0, 13'b0_0100_10011101});
`endif
    issue_exp(13'b0_1111_11111111, 13'b0_1111_11111111, {1'b1, 13'b0_1111_11111111});
    issue_exp(13'b0_0010_10000000, 13'b1_0010_10000000, 14'h0);
    issue_exp(13'b1_0101_00000000, 13'b1_0011_10100000, {1'b0, 13'b1_0011_10100000});
    issue_exp(13'b1_0101_00000000, 13'b1_0011_00000000, 14'h0);
    issue_exp(13'b0_0000_00000011, 13'b0_0000_00000101, {1'b0, 13'b0_0000_00001000});
    issue_exp(13'b0_1111_10000000, 13'b0_0000_10000000, {1'b0, 13'b0_1111_10000000});
    issue_exp(13'b0_0000_11000000, 13'b1_0000_10100000, {1'b0, 13'b0_0000_00100000});
    issue_exp(13'b0_0101_10000000, 13'b1_0100_11111111, {1'b0, 13'b0_0000_00010000});
    idle(3);
    @(negedge clk);
    check("hold_when_idle", {2'b00, overflow, result}, {2'b00, last_exp});

    for (int i = 0; i < 300; i++) begin
      x = rnd_op();
      case ($urandom_range(3))
        0: y = (x[7:0] != 0) ? {~x[12], x[11:8], x[7:3], 3'($urandom_range(7))} : rnd_op();
        1: begin
          y = rnd_op();
          y[12] = ~x[12];
          y[11:8] = (x[11:8] != 0) ? x[11:8] - 4'd1 : 4'd0;
        end
        default: y = rnd_op();
      endcase
      issue(x, y);
      if ($urandom_range(7) == 0) idle(1);
    end
    idle(3);

    issue(13'b0_0110_11000000, 13'b0_0010_10100000);
    idle(3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 13'b0_0100_10000000;
    b = 13'b0_0100_10000000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_beats_in_valid", {2'b00, out_valid, overflow, result}, 16'h0);

    issue(13'b1_0011_10010000, 13'b0_0001_11000000);
    issue(13'b0_1110_11110000, 13'b0_1110_10000000);
    idle(2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp13_adder.md
Name: fp13_adder

Overview:
- Single-cycle registered adder/subtractor for the team's 13-bit custom floating-point type `fp_t`.
- `fp_t` is packed as `{sign[12], exp[11:8], man[7:0]}`.
- Value = (-1)^sign × 0.man (binary fraction) × 2^exp, where exp is unsigned 0..15 with no bias.
- A normalized mantissa has `man[7]` = 1; a mantissa of 0 means zero.
- Used as the arithmetic core of the floating-point sum datapath.
- Inputs are captured on `in_valid`; the sum appears one clock later.

Parameters:
- EXP_W, 4, exponent field width.
- MAN_W, 8, mantissa field width.
- Total word width is 1+EXP_W+MAN_W (13 at defaults).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands `a`/`b` are valid this cycle.
- a  input  13  operand A (`fp_t`).
- b  input  13  operand B (`fp_t`).
- out_valid  output  1  `result` updated this cycle (1-cycle pulse per accepted input).
- result  output  13  registered sum a+b (`fp_t`).
- overflow  output  1  registered; 1 if the result saturated.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - On rst: `result` = 13'h0000, `out_valid` = 0, `overflow` = 0.
  - rst has priority over in_valid; an operation in flight is discarded.
- Handshake and latency:
  - If in_valid=1 at edge N, then at edge N+1 `result` and `overflow` hold the sum of the a/b sampled at N, and `out_valid`=1 for that one cycle.
  - If in_valid=0, `result` and `overflow` hold their previous values and `out_valid`=0.
  - Back-to-back inputs are accepted every cycle (throughput 1/cycle).
- Datapath (combinational between the input sample and the output register):
  1. Zero detect: an operand with man=0 is zero, regardless of its exp or sign. If one operand is zero, the result is the other operand unchanged. If both are zero, the result is +0 (all bits 0).
  2. Align: the operand with the larger exp is the big operand; ties are broken by comparing man, and the larger magnitude is big. The small mantissa shifts right by the exp difference.
     - Extend the small mantissa with guard, round and sticky bits.
     - A shift of 11 or more leaves only sticky.
  3. Add/sub: same signs add the mantissas; different signs subtract small from big. The result sign is the sign of the larger-magnitude operand.
  4. Exact cancellation gives +0 (13'h0000).
  5. Normalize:
     - Carry-out: shift right 1, exp+1.
     - Leading zeros: shift left until man[7]=1, decrementing exp, but stop at exp=0. This leaves an unnormalized result with exp 0 (gradual underflow; no flush).
  6. Rounding: truncate (drop guard/round/sticky) unless ROUND_NEAREST_EN is defined.
  7. Overflow: if exp would exceed 15, output {sign, 4'hF, 8'hFF} and set `overflow`=1. Otherwise `overflow`=0.
- Unnormalized inputs (man[7]=0, man≠0) are accepted and processed as their literal value.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined: round to nearest, ties to even, using the guard/round/sticky bits.
  - A mantissa carry from rounding renormalizes: exp+1, with the overflow rule reapplied.
- Not defined: truncation toward zero.
- Latency is 1 cycle in both builds.

Test Plan:
- a={0,0001,10000000}, b={0,0001,10000000} (1+1) -> result={0,0010,10000000}, out_valid pulse 1 cycle later, overflow=0.
- a={0,0111,10000000}, b={0,0001,10000000} (64+1) -> result={0,0111,10000010}.
- a={0,0011,10100000}, b={0,0010,10010000} (5+2.25) -> result={0,0011,11101000} (7.25).
- a={0,0000,10000000}, b={1,0001,11110000} (0.5-1.875) -> result={1,0001,10110000} (-1.375).
- a={0,0001,11110000}, b={0,0011,11111111} (1.875+7.96875):
  - without ROUND_NEAREST_EN -> {0,0100,10011101};
  - with ROUND_NEAREST_EN -> {0,0100,10011110}.
- Boundaries:
  - a={0,1111,11111111}+b={0,1111,11111111} -> {0,1111,11111111}, overflow=1.
  - a={0,0010,10000000}, b={1,0010,10000000} -> 13'h0000.
  - rst asserted in the same cycle as in_valid -> next cycle result=0, out_valid=0.
